// File: rtl/quad_velocity_estimator.sv
// -----------------------------------------------------------------------------
// quad_velocity_estimator
//
// Samples a 32-bit quadrature position count once every SAMPLE_DIV clocks,
// forms the wrap-safe signed delta between consecutive samples and outputs
// a boxcar average of the last N = 2^AVG_LOG2 deltas (counts per period).
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   enable      run/stop; low forces IDLE on the next edge
//   count       32-bit two's complement position count
//   velocity    signed averaged velocity (holds its value while idle)
//   vel_valid   one-cycle pulse when velocity updates
//   window_full high once N deltas have been accumulated since leaving IDLE
//   stalled     zero-motion flag (only with QVE_STALL_DETECT_EN, else 0)
//
// Pipeline for a sample tick at edge T:
//   T   : count captured, delta registered
//   T+1 : history shifted, running sum updated
//   T+2 : velocity / vel_valid updated
//
// Optional feature macro: QVE_STALL_DETECT_EN
// -----------------------------------------------------------------------------
module quad_velocity_estimator #(
  parameter int SAMPLE_DIV    = 50000,
  parameter int AVG_LOG2      = 2,
  parameter int STALL_SAMPLES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] count,
  output logic [31:0] velocity,
  output logic        vel_valid,
  output logic        window_full,
  output logic        stalled
);

  localparam int N  = 1 << AVG_LOG2;
  localparam int PW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam int SW = 32 + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SAMPLE_DIV - 1);
  localparam logic [CW-1:0] FILL_LAST  = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, PRIME, FILL, RUN} state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic [31:0]        prev_q, prev_d;
  logic [31:0]        delta_q, delta_d;
  logic               delta_vld_q, delta_vld_d;    // sum update pending
  logic               delta_emit_q, delta_emit_d;  // that update produces a pulse
  logic [CW-1:0]      fill_q, fill_d;              // deltas seen while filling
  logic signed [SW-1:0] sum_q, sum_d;
  logic               sum_emit_q, sum_emit_d;
  logic [31:0]        hist_q [N];
  logic [31:0]        hist_d [N];
  logic [31:0]        velocity_q, velocity_d;
  logic               vel_valid_q, vel_valid_d;
  logic               window_full_q, window_full_d;

  logic               tick;
  logic               active;
  logic [31:0]        raw_delta;
  logic signed [SW-1:0] new_ext, old_ext;

  assign tick      = (presc_q == PRESC_LAST);
  assign active    = enable && (state_q != IDLE);
  // Modulo-2^32 subtraction: counter wrap yields the correct small delta.
  assign raw_delta = count - prev_q;
  assign new_ext   = SW'($signed(delta_q));
  assign old_ext   = SW'($signed(hist_q[N-1]));

  always_comb begin
    state_d       = state_q;
    presc_d       = presc_q;
    prev_d        = prev_q;
    delta_d       = delta_q;
    delta_vld_d   = 1'b0;
    delta_emit_d  = 1'b0;
    fill_d        = fill_q;
    sum_d         = sum_q;
    sum_emit_d    = 1'b0;
    velocity_d    = velocity_q;
    vel_valid_d   = 1'b0;
    window_full_d = window_full_q;
    for (int i = 0; i < N; i++) hist_d[i] = hist_q[i];

    if (!active) begin
      // Dropping enable (even on a tick) discards in-flight work; velocity holds.
      state_d       = enable ? PRIME : IDLE;
      presc_d       = '0;
      fill_d        = '0;
      sum_d         = '0;
      window_full_d = 1'b0;
      for (int i = 0; i < N; i++) hist_d[i] = '0;
    end else begin
      presc_d = tick ? '0 : presc_q + PW'(1);

      if (sum_emit_q) begin
        velocity_d  = 32'(sum_q >>> AVG_LOG2);
        vel_valid_d = 1'b1;
      end

      if (delta_vld_q) begin
        sum_d      = sum_q + new_ext - old_ext;
        hist_d[0]  = delta_q;
        for (int i = 1; i < N; i++) hist_d[i] = hist_q[i-1];
        sum_emit_d = delta_emit_q;
      end

      if (tick) begin
        case (state_q)
          PRIME: begin
            prev_d  = count;
            state_d = FILL;
          end
          FILL, RUN: begin
            prev_d      = count;
            delta_d     = raw_delta;
            delta_vld_d = 1'b1;
            if (state_q == RUN) begin
              delta_emit_d = 1'b1;
            end else if (fill_q == FILL_LAST) begin
              delta_emit_d  = 1'b1;
              window_full_d = 1'b1;
              state_d       = RUN;
            end else begin
              fill_d = fill_q + CW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      presc_q       <= '0;
      prev_q        <= '0;
      delta_q       <= '0;
      delta_vld_q   <= 1'b0;
      delta_emit_q  <= 1'b0;
      fill_q        <= '0;
      sum_q         <= '0;
      sum_emit_q    <= 1'b0;
      velocity_q    <= '0;
      vel_valid_q   <= 1'b0;
      window_full_q <= 1'b0;
      for (int i = 0; i < N; i++) hist_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      prev_q        <= prev_d;
      delta_q       <= delta_d;
      delta_vld_q   <= delta_vld_d;
      delta_emit_q  <= delta_emit_d;
      fill_q        <= fill_d;
      sum_q         <= sum_d;
      sum_emit_q    <= sum_emit_d;
      velocity_q    <= velocity_d;
      vel_valid_q   <= vel_valid_d;
      window_full_q <= window_full_d;
      for (int i = 0; i < N; i++) hist_q[i] <= hist_d[i];
    end
  end

  assign velocity    = velocity_q;
  assign vel_valid   = vel_valid_q;
  assign window_full = window_full_q;

`ifdef QVE_STALL_DETECT_EN
  localparam int ZW = $clog2(STALL_SAMPLES + 1);
  localparam logic [ZW-1:0] ZLIM = ZW'(STALL_SAMPLES);

  logic [ZW-1:0] zrun_q, zrun_d;
  logic          stalled_q, stalled_d;

  // Judged on the same edge that registers the delta, so the flag rises on
  // the tick edge of the qualifying zero delta and drops on a moving one.
  always_comb begin
    zrun_d    = zrun_q;
    stalled_d = stalled_q;
    if (!active) begin
      zrun_d    = '0;
      stalled_d = 1'b0;
    end else if (tick && (state_q == FILL || state_q == RUN)) begin
      if (raw_delta == 32'd0) begin
        zrun_d    = (zrun_q == ZLIM) ? zrun_q : zrun_q + ZW'(1);
        stalled_d = (zrun_d == ZLIM);
      end else begin
        zrun_d    = '0;
        stalled_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      zrun_q    <= '0;
      stalled_q <= 1'b0;
    end else begin
      zrun_q    <= zrun_d;
      stalled_q <= stalled_d;
    end
  end

  assign stalled = stalled_q;
`else
  // STALL_SAMPLES only matters when stall detection is built in.
  logic unused_stall_cfg;
  assign unused_stall_cfg = (STALL_SAMPLES > 0);
  assign stalled = 1'b0;
`endif

endmodule

// File: tb/tb_quad_velocity_estimator.sv
// -----------------------------------------------------------------------------
// Testbench for quad_velocity_estimator (SAMPLE_DIV=10, AVG_LOG2=2).
// A session model predicts, for every clock edge, vel_valid, velocity,
// window_full and stalled from the list of sampled counts: deltas are
// consecutive differences, velocity is the floored mean of the last N deltas.
// -----------------------------------------------------------------------------
module tb_quad_velocity_estimator;

  localparam int SD    = 10;
  localparam int AL    = 2;
  localparam int N     = 4;
  localparam int STALL = 8;
`ifdef QVE_STALL_DETECT_EN
  localparam bit STALL_ON = 1'b1;
`else
  localparam bit STALL_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] count;
  logic [31:0] velocity;
  logic        vel_valid;
  logic        window_full;
  logic        stalled;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_vel_g = 32'd0;
  logic [31:0] samp [16];

  always #5 clk = ~clk;

  quad_velocity_estimator #(
    .SAMPLE_DIV   (SD),
    .AVG_LOG2     (AL),
    .STALL_SAMPLES(STALL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .count      (count),
    .velocity   (velocity),
    .vel_valid  (vel_valid),
    .window_full(window_full),
    .stalled    (stalled)
  );

  typedef struct {
    logic [31:0] start;
    int          d [6];
    logic [31:0] exp_vel;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int sdelta(input int k);
    logic [31:0] diff;
    diff = samp[k] - samp[k-1];
    return $signed(diff);
  endfunction

  // Floored mean of the N deltas ending at sample k.
  function automatic logic [31:0] model_vel(input int k);
    longint s;
    longint q;
    s = 0;
    for (int j = k - N + 1; j <= k; j++) s += longint'(sdelta(j));
    q = s / N;
    if ((s % N) != 0 && s < 0) q = q - 1;
    return q[31:0];
  endfunction

  // Runs one enabled session over samp[0..ns-1]; enable drops for edge stop_c.
  task automatic run_seq(input int ns, input int stop_c, input string tag);
    int   zr;
    int   k;
    logic wf, st, vv;
    zr = 0; wf = 1'b0; st = 1'b0;
    enable = 1'b1;
    count  = samp[0];
    for (int c = 0; c < stop_c; c++) begin
      @(posedge clk); #1;
      if (c > 0 && c % SD == 0) begin
        k = c / SD - 1;
        if (k >= 1 && k < ns) begin
          if (sdelta(k) == 0) begin
            if (zr < STALL) zr++;
          end else begin
            zr = 0;
          end
          st = (zr >= STALL);
          if (k == N) wf = 1'b1;
        end
      end
      vv = 1'b0;
      if (c > 2 && (c - 2) % SD == 0) begin
        k = (c - 2) / SD - 1;
        if (k >= N && k < ns) begin
          vv = 1'b1;
          exp_vel_g = model_vel(k);
        end
      end
      chk($sformatf("%s c=%0d vel_valid", tag, c), {31'd0, vel_valid}, {31'd0, vv});
      chk($sformatf("%s c=%0d velocity", tag, c), velocity, exp_vel_g);
      chk($sformatf("%s c=%0d window_full", tag, c), {31'd0, window_full}, {31'd0, wf});
      chk($sformatf("%s c=%0d stalled", tag, c), {31'd0, stalled}, {31'd0, st & STALL_ON});
      if ((c + 1) % SD == 0) begin
        k = (c + 1) / SD - 1;
        count = (k < ns) ? samp[k] : samp[ns-1];
      end else begin
        count = $urandom;  // off-tick values must be ignored
      end
    end
    enable = 1'b0;
    @(posedge clk); #1;
    chk($sformatf("%s idle vel_valid", tag), {31'd0, vel_valid}, 32'd0);
    chk($sformatf("%s idle velocity", tag), velocity, exp_vel_g);
    chk($sformatf("%s idle window_full", tag), {31'd0, window_full}, 32'd0);
    chk($sformatf("%s idle stalled", tag), {31'd0, stalled}, 32'd0);
    $display("[TB] session %s: %0d samples, stop at cycle %0d, velocity %h", tag, ns, stop_c, exp_vel_g);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [8];
    int   ns, stop_c, mode, d;

    tbl[0] = '{32'h0000_0000, '{5, 5, 5, 5, 5, 5}, 32'd5};
    tbl[1] = '{32'h0000_0064, '{0, 0, -3, -3, -3, -2}, 32'hFFFF_FFFD};
    tbl[2] = '{32'h0000_03E8, '{-7, -7, -7, -7, -7, -7}, 32'hFFFF_FFF9};
    tbl[3] = '{32'hFFFF_FFFE, '{5, 5, 5, 5, 5, 5}, 32'd5};
    tbl[4] = '{32'h7FFF_FFFF, '{2, 2, 2, 2, 2, 2}, 32'd2};
    tbl[5] = '{32'h0000_0000, '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
                               32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF}, 32'h7FFF_FFFF};
    tbl[6] = '{32'h0000_0000, '{int'(32'h8000_0000), int'(32'h8000_0000), int'(32'h8000_0000),
                               int'(32'h8000_0000), int'(32'h8000_0000), int'(32'h8000_0000)}, 32'h8000_0000};
    tbl[7] = '{32'h0000_0032, '{100, -50, 7, 1, -1, -3}, 32'd1};

    // Reset with enable high and a nonzero count.
    reset = 1'b1; enable = 1'b1; count = 32'd123;
    repeat (3) @(posedge clk);
    #1;
    chk("reset velocity", velocity, 32'd0);
    chk("reset vel_valid", {31'd0, vel_valid}, 32'd0);
    chk("reset window_full", {31'd0, window_full}, 32'd0);
    chk("reset stalled", {31'd0, stalled}, 32'd0);
    reset = 1'b0; enable = 1'b0; count = 32'd0;
    for (int c = 0; c < 2 * SD; c++) begin
      @(posedge clk); #1;
      chk($sformatf("post-reset idle c=%0d vel_valid", c), {31'd0, vel_valid}, 32'd0);
    end

    // Table-driven sessions: 7 samples, 6 deltas each.
    for (int i = 0; i < 8; i++) begin
      samp[0] = tbl[i].start;
      for (int j = 0; j < 6; j++) samp[j+1] = samp[j] + 32'(tbl[i].d[j]);
      run_seq(7, 7 * SD + 4, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d final velocity", i), velocity, tbl[i].exp_vel);
    end

    // Enable drops on the edge where the first pulse would appear.
    for (int j = 0; j < 7; j++) samp[j] = 32'(5 * j);
    run_seq(7, (N + 1) * SD + 2, "drop");
    chk("drop velocity held", velocity, 32'd1);
    run_seq(7, 7 * SD + 4, "reenable");
    chk("reenable final velocity", velocity, 32'd5);

    // Enable drops exactly on a tick edge: that sample is discarded.
    run_seq(7, 6 * SD, "drop-on-tick");

    // Nine zero deltas, then one count of motion.
    for (int j = 0; j < 10; j++) samp[j] = 32'd42;
    samp[10] = 32'd43;
    run_seq(11, 11 * SD + 4, "stall");

    // Randomized sessions, including random enable drop points.
    for (int r = 0; r < 16; r++) begin
      ns   = $urandom_range(1, 10);
      mode = $urandom_range(0, 2);
      samp[0] = $urandom;
      for (int j = 1; j < ns; j++) begin
        case (mode)
          0:       d = int'($urandom_range(0, 40)) - 20;
          1:       d = $urandom;
          default: d = ($urandom_range(0, 3) == 0) ? 1 : 0;
        endcase
        samp[j] = samp[j-1] + 32'(d);
      end
      stop_c = ($urandom_range(0, 1) == 0) ? ns * SD + 4 : $urandom_range(1, ns * SD + 4);
      run_seq(ns, stop_c, $sformatf("rand%0d", r));
    end

    // Reset in RUN with a pulse in flight.
    for (int j = 0; j < 8; j++) samp[j] = 32'(3 * j);
    enable = 1'b1;
    for (int c = 0; c <= (N + 1) * SD; c++) begin
      count = samp[c / SD];
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    exp_vel_g = 32'd0;
    chk("midrun reset velocity", velocity, 32'd0);
    chk("midrun reset vel_valid", {31'd0, vel_valid}, 32'd0);
    chk("midrun reset window_full", {31'd0, window_full}, 32'd0);
    chk("midrun reset stalled", {31'd0, stalled}, 32'd0);
    reset = 1'b0; enable = 1'b0;
    for (int c = 0; c < 3 * SD; c++) begin
      @(posedge clk); #1;
      chk($sformatf("after reset c=%0d vel_valid", c), {31'd0, vel_valid}, 32'd0);
      chk($sformatf("after reset c=%0d velocity", c), velocity, 32'd0);
    end
    $display("[TB] session midrun-reset: pending pulse cancelled check done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
